// File: rtl/thermal_frame_writer.sv
// Thermal frame writer: scales raw 16-bit sensor pixels to 8 bits with
// saturation and writes them into one half of a double-buffered 16 KiB
// readout memory. Banks swap only after a complete frame, and only while
// the SPI side is not reading.
module thermal_frame_writer #(
  parameter int          PIXELS_PER_FRAME = 768,
  parameter logic [15:0] PIXEL_OFFSET     = 16'd0,
  parameter int          PIXEL_SHIFT      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [15:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic        read_busy,
  output logic        mem_write_enable,
  output logic [13:0] mem_write_address,
  output logic [7:0]  mem_write_data,
  output logic        read_bank,
  output logic        frame_done,
  output logic        overrun_error
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, SWAP} state_t;

  // Index is 14 bits wide so a full 8192-pixel frame count fits.
  localparam logic [13:0] FRAME_LEN  = 14'(PIXELS_PER_FRAME);
  localparam logic [13:0] LAST_INDEX = 14'(PIXELS_PER_FRAME - 1);

  state_t       state, next_state;
  logic [13:0]  pixel_index, next_index;
  logic         drain_count, next_drain_count;
  logic         busy_meta, read_busy_sync;
  logic         write_bank;
  logic         accept, swap, overrun_set;

  logic               s1_valid;
  logic [13:0]        s1_address;
  logic signed [16:0] s1_diff;
  logic [15:0]        shifted;
  logic [7:0]         scaled;

  assign write_bank  = ~read_bank;
  assign pixel_ready = (state == CAPTURE) && (pixel_index < FRAME_LEN);
  assign accept      = pixel_valid && pixel_ready;

  // Two-flop synchronizer for the asynchronous SPI chip select.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling the pre-edge
    // value of its source; blocking here would collapse the two stages.
    if (reset) begin
      busy_meta      <= 1'b0;
      read_busy_sync <= 1'b0;
    end else begin
      busy_meta      <= read_busy;
      read_busy_sync <= busy_meta;
    end
  end

  // Next-state logic for the capture / drain / swap sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    next_state       = state;
    next_index       = pixel_index;
    next_drain_count = drain_count;
    swap             = 1'b0;
    overrun_set      = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          next_index = '0;
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (frame_start) begin
          // Restart on the same bank; pixels already in the pipeline still land.
          overrun_set = 1'b1;
          next_index  = '0;
        end else if (accept) begin
          next_index = pixel_index + 14'd1;
          if (pixel_index == LAST_INDEX) begin
            next_state       = DRAIN;
            next_drain_count = 1'b0;
          end
        end
      end
      DRAIN: begin
        overrun_set      = frame_start;
        next_drain_count = 1'b1;
        if (drain_count) next_state = SWAP;
      end
      SWAP: begin
        overrun_set = frame_start;
        if (!read_busy_sync) begin
          swap       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Control registers: state, index, bank select and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pixel_index   <= '0;
      drain_count   <= 1'b0;
      read_bank     <= 1'b1;
      frame_done    <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      state         <= next_state;
      pixel_index   <= next_index;
      drain_count   <= next_drain_count;
      read_bank     <= read_bank ^ swap;
      frame_done    <= swap;
      overrun_error <= overrun_error | overrun_set;
    end
  end

  // Stage-2 scaling: clamp negatives to 0, shift, saturate at 255.
  always_comb begin
    shifted = '0;
    scaled  = '0;
    if (!s1_diff[16]) begin
      shifted = s1_diff[15:0] >> PIXEL_SHIFT;
      scaled  = (shifted > 16'd255) ? 8'hFF : shifted[7:0];
    end
  end

  // Two-stage pixel pipeline feeding the memory write port.
  always_ff @(posedge clk) begin
    // NOTE: the data-path registers are reset too, so a reset mid-frame
    // flushes in-flight pixels and the write port reads all-zero afterwards.
    if (reset) begin
      s1_valid          <= 1'b0;
      s1_address        <= '0;
      s1_diff           <= '0;
      mem_write_enable  <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_address <= {write_bank, pixel_index[12:0]};
        s1_diff    <= $signed({1'b0, pixel_data}) - $signed({1'b0, PIXEL_OFFSET});
      end
      mem_write_enable <= s1_valid;
      if (s1_valid) begin
        mem_write_address <= s1_address;
        mem_write_data    <= scaled;
      end
    end
  end

endmodule

// File: tb/tb_thermal_frame_writer.sv
// Directed bench for thermal_frame_writer: a default-parameter instance for
// frame, swap, restart and reset scenarios, and a small offset/shift instance
// for the scaling and latency checks.
module tb_thermal_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start, pixel_valid, read_busy;
  logic [15:0] pixel_data;
  logic        pixel_ready, mem_write_enable, read_bank, frame_done, overrun_error;
  logic [13:0] mem_write_address;
  logic [7:0]  mem_write_data;

  logic        s_frame_start, s_pixel_valid, s_read_busy;
  logic [15:0] s_pixel_data;
  logic        s_pixel_ready, s_mem_write_enable, s_read_bank, s_frame_done, s_overrun_error;
  logic [13:0] s_mem_write_address;
  logic [7:0]  s_mem_write_data;

  int errors = 0;
  int checks = 0;

  // Write log, indexed by byte address; entries from older epochs count as unwritten.
  int          cur_epoch = 1;
  int          wr_total  = 0;
  int          fd_cnt    = 0;
  int          wr_epoch[16384];
  int          wr_cnt[16384];
  logic [7:0]  wr_data[16384];

  always #5 clk = ~clk;

  thermal_frame_writer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .read_busy(read_busy),
    .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .read_bank(read_bank), .frame_done(frame_done),
    .overrun_error(overrun_error)
  );

  thermal_frame_writer #(.PIXELS_PER_FRAME(4), .PIXEL_OFFSET(16'd100), .PIXEL_SHIFT(4)) dut_sat (
    .clk(clk), .reset(reset), .frame_start(s_frame_start), .pixel_data(s_pixel_data),
    .pixel_valid(s_pixel_valid), .pixel_ready(s_pixel_ready), .read_busy(s_read_busy),
    .mem_write_enable(s_mem_write_enable), .mem_write_address(s_mem_write_address),
    .mem_write_data(s_mem_write_data), .read_bank(s_read_bank), .frame_done(s_frame_done),
    .overrun_error(s_overrun_error)
  );

  // Write monitor for the main instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_write_enable) begin
      wr_epoch[mem_write_address] <= cur_epoch;
      wr_cnt[mem_write_address]   <= (wr_epoch[mem_write_address] == cur_epoch) ?
                                     wr_cnt[mem_write_address] + 1 : 1;
      wr_data[mem_write_address]  <= mem_write_data;
      wr_total                    <= wr_total + 1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  function automatic int cnt_of(input int a);
    return (wr_epoch[a] == cur_epoch) ? wr_cnt[a] : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    frame_start = 1'b0; pixel_valid = 1'b0; pixel_data = '0; read_busy = 1'b0;
    s_frame_start = 1'b0; s_pixel_valid = 1'b0; s_pixel_data = '0; s_read_busy = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Present pixels 16*(i mod 256); optional fixed gap pattern on pixel_valid.
  task automatic feed_pixels(input int n, input bit gaps, output int accepted);
    int  k;
    bit  acc;
    accepted = 0;
    k = 0;
    while (accepted < n && k < 4000) begin
      pixel_valid = gaps ? (((k % 3) != 0) && ((k % 7) != 4)) : 1'b1;
      pixel_data  = 16'(16 * (accepted % 256));
      @(negedge clk);
      acc = pixel_valid && pixel_ready;
      tick();
      if (acc) accepted++;
      k++;
    end
    pixel_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    tick();
  endtask

  task automatic count_bad(input int base, output int bad);
    bad = 0;
    for (int i = 0; i < 768; i++)
      if (cnt_of(base + i) != 1 || wr_data[base + i] !== 8'(i % 256)) bad++;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (read_bank !== 1'b1) begin errors++; $display("FAIL reset_read_bank: got %0b expected 1", read_bank); end
    checks++; if (pixel_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", pixel_ready); end
    checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", mem_write_enable); end
    checks++; if (overrun_error !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovr=%0b done=%0b expected 0/0", overrun_error, frame_done); end
    checks++; if (mem_write_address !== 14'h0 || mem_write_data !== 8'h0) begin errors++; $display("FAIL reset_bus: got addr=%0h data=%0h expected 0/0", mem_write_address, mem_write_data); end
    tick();
  endtask

  task automatic test_full_frame();
    int acc, bad, w0, f0;
    bit seen;
    cur_epoch++;
    w0 = wr_total; f0 = fd_cnt;
    start_frame();
    feed_pixels(768, 1'b0, acc);
    wait_done(seen);
    repeat (3) tick();
    count_bad(0, bad);
    checks++; if (acc !== 768) begin errors++; $display("FAIL t1_accepted: got %0d expected 768", acc); end
    checks++; if (!seen) begin errors++; $display("FAIL t1_frame_done: got none expected pulse"); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL t1_contents: got %0d bad addresses expected 0", bad); end
    checks++; if (wr_total - w0 !== 768) begin errors++; $display("FAIL t1_write_count: got %0d expected 768", wr_total - w0); end
    checks++; if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL t1_done_count: got %0d expected 1", fd_cnt - f0); end
    checks++; if (read_bank !== 1'b0) begin errors++; $display("FAIL t1_read_bank: got %0b expected 0", read_bank); end
    checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL t1_overrun: got %0b expected 0", overrun_error); end
  endtask

  task automatic test_saturation();
    logic [15:0] pix [4];
    logic [7:0]  exp [4];
    bit seen;
    pix[0] = 16'd50;    exp[0] = 8'd0;
    pix[1] = 16'd116;   exp[1] = 8'd1;
    pix[2] = 16'd65535; exp[2] = 8'd255;
    pix[3] = 16'd4195;  exp[3] = 8'd255;
    s_frame_start = 1'b1;
    tick();
    s_frame_start = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      s_pixel_valid = (c < 4);
      s_pixel_data  = (c < 4) ? pix[c] : 16'h0;
      @(negedge clk);
      if (c < 4) begin
        checks++; if (s_pixel_ready !== 1'b1) begin errors++; $display("FAIL t2_ready%0d: got %0b expected 1", c, s_pixel_ready); end
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (s_mem_write_enable !== 1'b1 || s_mem_write_address !== 14'(c - 2) || s_mem_write_data !== exp[c - 2]) begin
          errors++;
          $display("FAIL t2_write%0d: got we=%0b addr=%0h data=%0d expected we=1 addr=%0h data=%0d",
                   c - 2, s_mem_write_enable, s_mem_write_address, s_mem_write_data, c - 2, exp[c - 2]);
        end
      end else begin
        checks++; if (s_mem_write_enable !== 1'b0) begin errors++; $display("FAIL t2_idle_cycle%0d: got we=%0b expected 0", c, s_mem_write_enable); end
      end
      tick();
    end
    s_pixel_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (s_frame_done) seen = 1'b1;
    end
    tick();
    checks++; if (!seen || s_read_bank !== 1'b0) begin errors++; $display("FAIL t2_swap: got done=%0b bank=%0b expected 1/0", seen, s_read_bank); end
  endtask

  task automatic test_restart();
    int acc, w0;
    bit got;
    logic [13:0] a;
    logic [7:0]  d;
    cur_epoch++;
    start_frame();
    feed_pixels(300, 1'b0, acc);
    start_frame();
    repeat (3) tick();
    @(negedge clk);
    checks++; if (overrun_error !== 1'b1) begin errors++; $display("FAIL t5_overrun: got %0b expected 1", overrun_error); end
    checks++; if (pixel_ready !== 1'b1) begin errors++; $display("FAIL t5_still_capture: got ready=%0b expected 1", pixel_ready); end
    tick();
    checks++; if (cnt_of(14'h2000 + 299) !== 1 || wr_data[14'h2000 + 299] !== 8'd43) begin errors++; $display("FAIL t5_inflight: got cnt=%0d data=%0d expected 1/43", cnt_of(14'h2000 + 299), wr_data[14'h2000 + 299]); end
    w0 = wr_total;
    pixel_valid = 1'b1; pixel_data = 16'd112;
    tick();
    pixel_valid = 1'b0;
    got = 1'b0; a = '0; d = '0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(negedge clk);
      if (mem_write_enable) begin got = 1'b1; a = mem_write_address; d = mem_write_data; end
    end
    tick();
    checks++; if (!got || a !== 14'h2000 || d !== 8'd7) begin errors++; $display("FAIL t5_next_write: got seen=%0b addr=%0h data=%0d expected 1/2000/7", got, a, d); end
    checks++; if (wr_total - w0 !== 1) begin errors++; $display("FAIL t5_write_count: got %0d expected 1", wr_total - w0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_total;
    pixel_valid = 1'b1; pixel_data = 16'd160;
    tick();
    pixel_valid = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    checks++; if (wr_total !== w0) begin errors++; $display("FAIL t6_no_write: got %0d writes expected 0", wr_total - w0); end
    checks++; if (read_bank !== 1'b1) begin errors++; $display("FAIL t6_read_bank: got %0b expected 1", read_bank); end
    checks++; if (overrun_error !== 1'b0 || pixel_ready !== 1'b0) begin errors++; $display("FAIL t6_flags: got ovr=%0b ready=%0b expected 0/0", overrun_error, pixel_ready); end
    checks++; if (mem_write_address !== 14'h0 || mem_write_data !== 8'h0) begin errors++; $display("FAIL t6_bus: got addr=%0h data=%0h expected 0/0", mem_write_address, mem_write_data); end
    tick();
  endtask

  task automatic test_held_swap();
    int acc, f0, n;
    read_busy = 1'b1;
    f0 = fd_cnt;
    start_frame();
    feed_pixels(768, 1'b0, acc);
    repeat (10) tick();
    checks++; if (read_bank !== 1'b1 || fd_cnt !== f0) begin errors++; $display("FAIL t3_held: got bank=%0b dones=%0d expected 1/0", read_bank, fd_cnt - f0); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    checks++; if (overrun_error !== 1'b1 || pixel_ready !== 1'b0) begin errors++; $display("FAIL t3_start_in_swap: got ovr=%0b ready=%0b expected 1/0", overrun_error, pixel_ready); end
    tick();
    read_busy = 1'b0;
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      @(negedge clk);
      if (read_bank == 1'b0) begin
        n = k;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL t3_done_with_swap: got %0b expected 1", frame_done); end
      end
    end
    repeat (5) tick();
    checks++; if (n < 3 || n > 4) begin errors++; $display("FAIL t3_swap_delay: got %0d cycles expected 3..4", n); end
    checks++; if (fd_cnt - f0 !== 1 || read_bank !== 1'b0) begin errors++; $display("FAIL t3_single_swap: got dones=%0d bank=%0b expected 1/0", fd_cnt - f0, read_bank); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, bad1, bad2, w0;
    bit seen1, seen2;
    apply_reset();
    cur_epoch++;
    w0 = wr_total;
    start_frame();
    feed_pixels(768, 1'b1, acc1);
    wait_done(seen1);
    start_frame();
    feed_pixels(768, 1'b1, acc2);
    wait_done(seen2);
    repeat (3) tick();
    count_bad(0, bad1);
    count_bad(14'h2000, bad2);
    checks++; if (acc1 !== 768 || acc2 !== 768) begin errors++; $display("FAIL t4_accepted: got %0d/%0d expected 768/768", acc1, acc2); end
    checks++; if (!seen1 || !seen2) begin errors++; $display("FAIL t4_done: got %0b/%0b expected 1/1", seen1, seen2); end
    checks++; if (bad1 !== 0) begin errors++; $display("FAIL t4_frame1: got %0d bad addresses expected 0", bad1); end
    checks++; if (bad2 !== 0) begin errors++; $display("FAIL t4_frame2: got %0d bad addresses expected 0", bad2); end
    checks++; if (wr_total - w0 !== 1536) begin errors++; $display("FAIL t4_write_count: got %0d expected 1536", wr_total - w0); end
    checks++; if (read_bank !== 1'b1) begin errors++; $display("FAIL t4_read_bank: got %0b expected 1", read_bank); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_saturation();
    test_restart();
    test_reset_mid();
    test_held_swap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
